// File: rtl/axi_store_buffer.sv
// Posted-write store buffer: queues aligned stores and retires them in order as single-beat AXI writes.
// Accept-to-AWVALID is 2 cycles, one transaction outstanding; st_ready drops only when the FIFO is full.
module axi_store_buffer #(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_strb,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  output logic        sb_empty,
  output logic        sb_err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;
  state_t state, next_state;

  logic [29:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    strb_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          aw_done, w_done;
  logic          push, pop, fifo_empty;
  logic          unused_ok;

  // st_ready looks only at the registered count, so a full buffer stalls even on a pop cycle.
  assign fifo_empty = (count == '0);
  assign st_ready   = (count != FULL_CNT);
  assign push       = st_valid && st_ready && (st_strb != 4'b0000);
  assign pop        = (state == RESP) && BVALID;
  assign unused_ok  = ^{BID, st_addr[1:0]};

  assign AWID     = AXI_ID;
  assign AWADDR   = {addr_mem[rd_ptr], 2'b00};
  assign AWLEN    = 4'd0;
  assign AWSIZE   = 3'b010;
  assign AWBURST  = 2'b01;
  assign WDATA    = data_mem[rd_ptr];
  assign WSTRB    = strb_mem[rd_ptr];
  assign WLAST    = 1'b1;
  assign sb_empty = fifo_empty && (state == IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= st_addr[31:2];
      data_mem[wr_ptr] <= st_data;
      strb_mem[wr_ptr] <= st_strb;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    BREADY     = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) next_state = SEND;
      SEND: begin
        AWVALID = !aw_done;
        WVALID  = !w_done;
        if ((aw_done || AWREADY) && (w_done || WREADY)) next_state = RESP;
      end
      RESP: begin
        BREADY = 1'b1;
        if (BVALID) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      sb_err  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && !fifo_empty) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == SEND) begin
        if (AWVALID && AWREADY) aw_done <= 1'b1;
        if (WVALID && WREADY)   w_done  <= 1'b1;
      end
      if (pop && BRESP != 2'b00) sb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_store_buffer.sv
// Bench for axi_store_buffer: AXI slave model with a scoreboard of expected writes and responses.
module tb_axi_store_buffer;
  localparam int         DEPTH  = 4;
  localparam logic [3:0] AXI_ID = 4'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st_valid = 1'b0, st_ready;
  logic [31:0] st_addr = '0, st_data = '0;
  logic [3:0]  st_strb = '0;
  logic [3:0]  AWID, AWLEN;
  logic [31:0] AWADDR, WDATA;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, WVALID, WLAST, BREADY, sb_empty, sb_err;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [3:0]  WSTRB;
  logic [3:0]  BID = 4'd0;
  logic [1:0]  BRESP = 2'b00;

  axi_store_buffer #(.DEPTH(DEPTH), .AXI_ID(AXI_ID)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_strb(st_strb), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .sb_empty(sb_empty), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int n_checks = 0, n_fail = 0, cyc = 0;
  int aw_hs_cnt = 0, last_pop_edge = -1;
  logic aw_rdy_en = 1'b0, w_rdy_en = 1'b0;
  logic got_aw = 0, got_w = 0, b_due = 0, b_hs = 0, exp_err = 0;
  logic prev_aw_pend = 0, prev_w_pend = 0;
  logic [31:0] cap_addr = '0, cap_data = '0, prev_awaddr = '0, prev_wdata = '0;
  logic [3:0]  cap_strb = '0;
  logic [1:0]  cur_resp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and monitor; evaluates the handshakes that the next rising edge will complete.
  always @(negedge clk) begin
    if (rst) begin
      got_aw = 0; got_w = 0; b_due = 0; b_hs = 0; exp_err = 0;
      prev_aw_pend = 0; prev_w_pend = 0; BVALID = 0; BRESP = 2'b00;
      AWREADY = aw_rdy_en; WREADY = w_rdy_en;
    end else begin
      if (prev_aw_pend) begin
        n_checks++;
        if (AWVALID !== 1'b1 || AWADDR !== prev_awaddr) begin
          n_fail++;
          $display("FAIL aw_hold: AWVALID=%b AWADDR=%h, required 1 and %h", AWVALID, AWADDR, prev_awaddr);
        end
      end
      if (prev_w_pend) begin
        n_checks++;
        if (WVALID !== 1'b1 || WDATA !== prev_wdata) begin
          n_fail++;
          $display("FAIL w_hold: WVALID=%b WDATA=%h, required 1 and %h", WVALID, WDATA, prev_wdata);
        end
      end
      if (BREADY) begin
        n_checks++;
        if (got_aw || got_w) begin
          n_fail++;
          $display("FAIL bready_early: got_aw=%b got_w=%b, required both handshakes paired", got_aw, got_w);
        end
      end
      if (b_hs) begin
        BVALID = 0; b_hs = 0;
        exp_err = exp_err | (cur_resp != 2'b00);
        n_checks++;
        if (sb_err !== exp_err) begin
          n_fail++;
          $display("FAIL sb_err_after_b: got %b, required %b", sb_err, exp_err);
        end
      end
      if (b_due) begin
        BVALID = 1; BRESP = cur_resp; b_due = 0;
      end
      AWREADY = aw_rdy_en;
      WREADY  = w_rdy_en;
      prev_aw_pend = AWVALID && !AWREADY; prev_awaddr = AWADDR;
      prev_w_pend  = WVALID && !WREADY;   prev_wdata  = WDATA;
      if (AWVALID && AWREADY) begin got_aw = 1; cap_addr = AWADDR; aw_hs_cnt++; end
      if (WVALID && WREADY) begin got_w = 1; cap_data = WDATA; cap_strb = WSTRB; end
      if (got_aw && got_w) begin
        got_aw = 0; got_w = 0; b_due = 1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_txn: addr=%h data=%h, required no transaction", cap_addr, cap_data);
        end else begin
          cur = exp_q.pop_front();
          cur_resp = cur.resp;
          if (cap_addr !== cur.addr || cap_data !== cur.data || cap_strb !== cur.strb) begin
            n_fail++;
            $display("FAIL txn_payload: got %h/%h/%b, required %h/%h/%b",
                     cap_addr, cap_data, cap_strb, cur.addr, cur.data, cur.strb);
          end
        end
      end
      if (BVALID && BREADY) begin b_hs = 1; last_pop_edge = cyc + 1; end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] r, output int acc, output int waited);
    st_valid = 1'b1; st_addr = a; st_data = d; st_strb = s;
    waited = 0;
    while (!st_ready && waited < 200) begin @(posedge clk); #1; waited++; end
    if (!st_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: st_ready=%b, required 1 within 200 cycles", st_ready);
      st_valid = 1'b0; acc = -1;
    end else begin
      if (s != 4'b0000) exp_q.push_back(exp_t'{addr: a & 32'hFFFF_FFFC, data: d, strb: s, resp: r});
      @(posedge clk); #1;
      st_valid = 1'b0;
      acc = cyc;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(sb_empty && exp_q.size() == 0 && !BVALID) && n < 300) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (!sb_empty || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: sb_empty=%b pending=%0d, required 1 and 0", name, sb_empty, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({st_ready, AWVALID, WVALID, BREADY, sb_empty, sb_err} !== 6'b100010) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 100010",
               {st_ready, AWVALID, WVALID, BREADY, sb_empty, sb_err});
    end
    n_checks++;
    if ({AWID, AWLEN, AWSIZE, AWBURST, WLAST} !== {AXI_ID, 4'd0, 3'b010, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_constants: got %h %h %b %b %b, required %h 0 010 01 1",
               AWID, AWLEN, AWSIZE, AWBURST, WLAST, AXI_ID);
    end
    n_checks++;
    if (dut.count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d, required 0", dut.count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int acc, w;
    aw_rdy_en = 1'b1; w_rdy_en = 1'b1;
    @(posedge clk); #1;
    push(32'h0000_1006, 32'h00AB_0000, 4'b0100, 2'b00, acc, w);
    n_checks++;
    if ({sb_empty, AWVALID} !== 2'b00) begin
      n_fail++; $display("FAIL single_k: sb_empty,AWVALID=%b, required 00", {sb_empty, AWVALID});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({AWVALID, WVALID} !== 2'b11 || AWADDR !== 32'h0000_1004 || WDATA !== 32'h00AB_0000 ||
        WSTRB !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_send: valids=%b AWADDR=%h WDATA=%h WSTRB=%b, required 11 00001004 00ab0000 0100",
               {AWVALID, WVALID}, AWADDR, WDATA, WSTRB);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({BREADY, AWVALID, WVALID, sb_empty} !== 4'b1000) begin
      n_fail++; $display("FAIL single_resp: got %b, required 1000", {BREADY, AWVALID, WVALID, sb_empty});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({sb_empty, BREADY} !== 2'b10) begin
      n_fail++; $display("FAIL single_done: sb_empty,BREADY=%b, required 10", {sb_empty, BREADY});
    end
    wait_drain("single");
  endtask

  task automatic test_fill();
    int acc, w, acc5, w5;
    aw_rdy_en = 1'b0; w_rdy_en = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(i * 4), 32'hF00D_0000 + 32'(i), 4'hF, 2'b00, acc, w);
    n_checks++;
    if (st_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: st_ready=%b, required 0", st_ready);
    end
    fork
      push(32'h2010, 32'hF00D_0004, 4'hF, 2'b00, acc5, w5);
      begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          n_checks++;
          if (st_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_held: st_ready=%b, required 0", st_ready);
          end
        end
        aw_rdy_en = 1'b1;
      end
    join
    n_checks++;
    if (w5 == 0 || acc5 != last_pop_edge + 1) begin
      n_fail++;
      $display("FAIL fill_fifth: waited=%0d accepted at edge %0d, required >0 and edge %0d",
               w5, acc5, last_pop_edge + 1);
    end
    wait_drain("fill");
  endtask

  task automatic test_skew();
    int acc, w;
    aw_rdy_en = 1'b0; w_rdy_en = 1'b0;
    push(32'h0000_300A, 32'h1234_5678, 4'b0011, 2'b00, acc, w);
    @(posedge clk); #1;
    n_checks++;
    if ({AWVALID, WVALID, BREADY} !== 3'b110) begin
      n_fail++; $display("FAIL skew_send: got %b, required 110", {AWVALID, WVALID, BREADY});
    end
    w_rdy_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({AWVALID, WVALID, BREADY} !== 3'b100 || AWADDR !== 32'h0000_3008) begin
        n_fail++;
        $display("FAIL skew_wait: valids=%b AWADDR=%h, required 100 00003008",
                 {AWVALID, WVALID, BREADY}, AWADDR);
      end
    end
    aw_rdy_en = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({AWVALID, WVALID, BREADY} !== 3'b001) begin
      n_fail++; $display("FAIL skew_resp: got %b, required 001", {AWVALID, WVALID, BREADY});
    end
    wait_drain("skew");
  endtask

  task automatic test_zero_strb();
    int acc, w, h0;
    aw_rdy_en = 1'b1; w_rdy_en = 1'b1;
    h0 = aw_hs_cnt;
    push(32'h0000_4001, 32'hDEAD_BEEF, 4'b0000, 2'b00, acc, w);
    n_checks++;
    if (w != 0) begin
      n_fail++; $display("FAIL zero_hs: waited %0d cycles, required 0", w);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (sb_empty !== 1'b1) begin
        n_fail++; $display("FAIL zero_empty: sb_empty=%b, required 1", sb_empty);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (aw_hs_cnt != h0) begin
      n_fail++; $display("FAIL zero_no_aw: %0d AW handshakes, required 0", aw_hs_cnt - h0);
    end
  endtask

  task automatic test_concurrent();
    int acc, w;
    aw_rdy_en = 1'b0; w_rdy_en = 1'b1;
    push(32'h5000, 32'hC0DE_0000, 4'hF, 2'b00, acc, w);
    push(32'h5004, 32'hC0DE_0001, 4'b1000, 2'b00, acc, w);
    repeat (3) begin @(posedge clk); #1; end
    aw_rdy_en = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (dut.count !== 3'd2 || BREADY !== 1'b1) begin
      n_fail++; $display("FAIL conc_pre: count=%0d BREADY=%b, required 2 and 1", dut.count, BREADY);
    end
    st_valid = 1'b1; st_addr = 32'h5008; st_data = 32'hC0DE_0002; st_strb = 4'b0001;
    exp_q.push_back(exp_t'{addr: 32'h5008, data: 32'hC0DE_0002, strb: 4'b0001, resp: 2'b00});
    @(posedge clk); #1;
    st_valid = 1'b0;
    n_checks++;
    if (dut.count !== 3'd2 || BREADY !== 1'b0) begin
      n_fail++; $display("FAIL conc_pushpop: count=%0d BREADY=%b, required 2 and 0", dut.count, BREADY);
    end
    wait_drain("concurrent");
  endtask

  task automatic test_err_reset();
    int acc, w, h0, n;
    aw_rdy_en = 1'b1; w_rdy_en = 1'b1;
    h0 = aw_hs_cnt;
    push(32'h6000, 32'h0000_0011, 4'hF, 2'b00, acc, w);
    push(32'h6004, 32'h0000_0022, 4'hF, 2'b10, acc, w);
    push(32'h6008, 32'h0000_0033, 4'hF, 2'b00, acc, w);
    wait_drain("err");
    n_checks++;
    if (sb_err !== 1'b1 || aw_hs_cnt - h0 != 3) begin
      n_fail++; $display("FAIL err_sticky: sb_err=%b AWs=%0d, required 1 and 3", sb_err, aw_hs_cnt - h0);
    end
    aw_rdy_en = 1'b0; w_rdy_en = 1'b0;
    push(32'h7000, 32'h0000_0044, 4'hF, 2'b00, acc, w);
    push(32'h7004, 32'h0000_0055, 4'hF, 2'b00, acc, w);
    n = 0;
    while (!AWVALID && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (AWVALID !== 1'b1) begin
      n_fail++; $display("FAIL rst_send: AWVALID=%b, required 1", AWVALID);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({st_ready, AWVALID, WVALID, BREADY, sb_empty, sb_err} !== 6'b100010 || dut.count !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: outputs=%b count=%0d, required 100010 and 0",
               {st_ready, AWVALID, WVALID, BREADY, sb_empty, sb_err}, dut.count);
    end
    rst = 1'b0;
    exp_q.delete();
    h0 = aw_hs_cnt;
    aw_rdy_en = 1'b1; w_rdy_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (AWVALID !== 1'b0 || sb_empty !== 1'b1) begin
        n_fail++; $display("FAIL rst_quiet: AWVALID=%b sb_empty=%b, required 0 and 1", AWVALID, sb_empty);
      end
    end
    n_checks++;
    if (aw_hs_cnt != h0) begin
      n_fail++; $display("FAIL rst_no_aw: %0d AW handshakes, required 0", aw_hs_cnt - h0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_skew();
    test_zero_strb();
    test_concurrent();
    test_err_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
